// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fb_pkg
//  Description : Shared definitions for the framebuffer arbiter: default
//                pixel address/data widths, RAM address width helper, the
//                starvation counter width and the bank-swap FSM encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package fb_pkg;

    localparam int c_fb_addr_width     = 9;   // 8 lines x 64 cols per bank
    localparam int c_fb_data_width     = 24;  // RGB888
    localparam int c_fb_ram_addr_width = c_fb_addr_width + 1;  // + bank select
    localparam int c_wait_cnt_width    = 8;

    // Bank-swap FSM encoding
    typedef enum logic [0:0] {
        SWAP_IDLE    = 1'b0,
        SWAP_PENDING = 1'b1
    } swap_state_t;

    // RAM address width for a given per-bank pixel address width
    function automatic int ram_addr_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fb_swap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fb_swap_ctrl
//  Description : Front/back bank swap controller. A swap request is latched
//                and takes effect on the next frame-boundary strobe, toggling
//                the front bank and emitting a one-cycle done pulse.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                i_frame_clk     - frame-boundary strobe
//                i_swap_req      - swap request (merged while pending)
//                o_front_bank    - bank currently scanned out
//                o_swap_done     - one-cycle pulse after the swap
//  Revision    : 1.0 - initial release
// ============================================================================
module fb_swap_ctrl
    import fb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_frame_clk,
    input  logic i_swap_req,
    output logic o_front_bank,
    output logic o_swap_done
);

    swap_state_t r_state;
    swap_state_t w_state_nxt;
    logic        r_front_bank;
    logic        r_swap_done;
    logic        w_swap_fire;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= SWAP_IDLE;
            r_front_bank <= 1'b0;
            r_swap_done  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_swap_done <= w_swap_fire;
            if (w_swap_fire) begin
                r_front_bank <= ~r_front_bank;
            end
        end
    end

    // A request arriving together with a frame strobe in IDLE only arms the
    // swap; it fires on the following strobe. Requests while PENDING merge.
    always_comb begin
        w_state_nxt = r_state;
        w_swap_fire = 1'b0;
        case (r_state)
            SWAP_IDLE: begin
                if (i_swap_req) begin
                    w_state_nxt = SWAP_PENDING;
                end
            end
            SWAP_PENDING: begin
                if (i_frame_clk) begin
                    w_swap_fire = 1'b1;
                    w_state_nxt = SWAP_IDLE;
                end
            end
            default: begin
                w_state_nxt = SWAP_IDLE;
            end
        endcase
    end

    assign o_front_bank = r_front_bank;
    assign o_swap_done  = r_swap_done;

endmodule
`default_nettype wire

// File: rtl/fb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fb_arbiter
//  Description : Shares a single-port, 1-cycle-latency framebuffer RAM between
//                the panel scan-out reader (priority) and a host pixel port.
//                A starvation counter forces a host slot after STARVE_LIMIT
//                consecutive stalled cycles.
//  Build macro : FB_DOUBLE_BUFFER_EN - enables front/back bank swapping on
//                frame_clk. When undefined both requesters share bank 0,
//                swap_req is ignored and swap_done stays 0.
//  Ports       : clk_in, reset          - clock, sync active-high reset
//                frame_clk, swap_req    - frame strobe, swap request
//                swap_done              - one-cycle swap pulse
//                scan_req/addr/gnt      - scan-out read request channel
//                scan_data(_valid)      - scan read return
//                host_valid/we/addr/wdata/ready - host request channel
//                host_rdata(_valid)     - host read return
//                ram_addr/we/wdata/rdata - RAM port (ram_addr MSB = bank)
//  Revision    : 1.0 - initial release
// ============================================================================
module fb_arbiter
    import fb_pkg::*;
#(
    parameter int ADDR_WIDTH   = c_fb_addr_width,
    parameter int DATA_WIDTH   = c_fb_data_width,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic                  frame_clk,
    input  logic                  scan_req,
    input  logic [ADDR_WIDTH-1:0] scan_addr,
    output logic                  scan_gnt,
    output logic [DATA_WIDTH-1:0] scan_data,
    output logic                  scan_data_valid,
    input  logic                  host_valid,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic                  host_ready,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic                  host_rdata_valid,
    input  logic                  swap_req,
    output logic                  swap_done,
    output logic [ADDR_WIDTH:0]   ram_addr,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    localparam int                          c_ram_aw       = ram_addr_width(ADDR_WIDTH);
    localparam logic [c_wait_cnt_width-1:0] c_starve_limit = c_wait_cnt_width'(STARVE_LIMIT);

    logic [c_wait_cnt_width-1:0] r_wait_cnt;
    logic [c_ram_aw-1:0]         r_ram_addr;
    logic [c_ram_aw-1:0]         w_ram_addr;
    logic                        r_scan_data_valid;
    logic                        r_host_rdata_valid;
    logic                        w_host_ready;
    logic                        w_scan_gnt;
    logic                        w_scan_bank;
    logic                        w_host_bank;
    logic                        w_swap_done;

    // ------------------------------------------------------------------
    // Bank mapping
    // ------------------------------------------------------------------
`ifdef FB_DOUBLE_BUFFER_EN
    logic w_front_bank;

    fb_swap_ctrl u_swap_ctrl (
        .clk          (clk_in),
        .rst          (reset),
        .i_frame_clk  (frame_clk),
        .i_swap_req   (swap_req),
        .o_front_bank (w_front_bank),
        .o_swap_done  (w_swap_done)
    );

    // Scan-out reads the front bank while the host draws into the back bank.
    assign w_scan_bank = w_front_bank;
    assign w_host_bank = ~w_front_bank;
`else
    logic w_unused;

    assign w_unused    = &{1'b0, swap_req, frame_clk};
    assign w_swap_done = 1'b0;
    assign w_scan_bank = 1'b0;
    assign w_host_bank = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Arbitration: scan has priority unless the host has waited its limit.
    // Both grants are forced low during reset.
    // ------------------------------------------------------------------
    assign w_host_ready = !reset && host_valid &&
                          (!scan_req || (r_wait_cnt == c_starve_limit));
    assign w_scan_gnt   = !reset && scan_req && !w_host_ready;

    // The RAM address is presented in the grant cycle and held otherwise.
    always_comb begin
        w_ram_addr = r_ram_addr;
        if (w_host_ready) begin
            w_ram_addr = {w_host_bank, host_addr};
        end else if (w_scan_gnt) begin
            w_ram_addr = {w_scan_bank, scan_addr};
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_wait_cnt         <= '0;
            r_ram_addr         <= '0;
            r_scan_data_valid  <= 1'b0;
            r_host_rdata_valid <= 1'b0;
        end else begin
            r_ram_addr         <= w_ram_addr;
            r_scan_data_valid  <= w_scan_gnt;
            r_host_rdata_valid <= w_host_ready && !host_we;
            if (w_host_ready) begin
                r_wait_cnt <= '0;
            end else if (host_valid && (r_wait_cnt < c_starve_limit)) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign scan_gnt         = w_scan_gnt;
    assign host_ready       = w_host_ready;
    assign ram_addr         = w_ram_addr;
    assign ram_we           = w_host_ready && host_we;
    assign ram_wdata        = host_wdata;
    assign scan_data        = ram_rdata;
    assign host_rdata       = ram_rdata;
    assign scan_data_valid  = r_scan_data_valid;
    assign host_rdata_valid = r_host_rdata_valid;
    assign swap_done        = w_swap_done;

endmodule
`default_nettype wire

// File: tb/tb_fb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fb_arbiter
//  Description : Self-checking bench for fb_arbiter. Stimulus is applied on
//                the falling edge; a reference model predicts grants, RAM
//                drive and swap behaviour, and queues expected read data for a
//                monitor that checks the returned words. Honours
//                FB_DOUBLE_BUFFER_EN for the expected bank mapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_arbiter;

    localparam int c_aw    = 9;
    localparam int c_dw    = 24;
    localparam int c_limit = 4;
    localparam int c_words = 1 << (c_aw + 1);

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            frame_clk = 1'b0;
    logic            scan_req = 1'b0;
    logic [c_aw-1:0] scan_addr = '0;
    logic            scan_gnt;
    logic [c_dw-1:0] scan_data;
    logic            scan_data_valid;
    logic            host_valid = 1'b0;
    logic            host_we = 1'b0;
    logic [c_aw-1:0] host_addr = '0;
    logic [c_dw-1:0] host_wdata = '0;
    logic            host_ready;
    logic [c_dw-1:0] host_rdata;
    logic            host_rdata_valid;
    logic            swap_req = 1'b0;
    logic            swap_done;
    logic [c_aw:0]   ram_addr;
    logic            ram_we;
    logic [c_dw-1:0] ram_wdata;
    logic [c_dw-1:0] ram_rdata;

    fb_arbiter #(
        .ADDR_WIDTH   (c_aw),
        .DATA_WIDTH   (c_dw),
        .STARVE_LIMIT (c_limit)
    ) dut (
        .clk_in           (clk),
        .reset            (reset),
        .frame_clk        (frame_clk),
        .scan_req         (scan_req),
        .scan_addr        (scan_addr),
        .scan_gnt         (scan_gnt),
        .scan_data        (scan_data),
        .scan_data_valid  (scan_data_valid),
        .host_valid       (host_valid),
        .host_we          (host_we),
        .host_addr        (host_addr),
        .host_wdata       (host_wdata),
        .host_ready       (host_ready),
        .host_rdata       (host_rdata),
        .host_rdata_valid (host_rdata_valid),
        .swap_req         (swap_req),
        .swap_done        (swap_done),
        .ram_addr         (ram_addr),
        .ram_we           (ram_we),
        .ram_wdata        (ram_wdata),
        .ram_rdata        (ram_rdata)
    );

    always #5 clk = ~clk;

    // ---------------- RAM environment (1-cycle read latency) -------------
    logic [c_dw-1:0] mem [0:c_words-1];
    logic            loaded = 1'b0;

    function automatic logic [c_dw-1:0] init_val(input int i);
        logic [31:0] h;
        h = (32'(i) * 32'h9E37_79B1) ^ 32'h005A_A5C3;
        return h[c_dw-1:0];
    endfunction

    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < c_words; i++) mem[i] <= init_val(i);
            loaded <= 1'b1;
        end else if (ram_we === 1'b1) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    // ---------------- checking infrastructure ----------------------------
    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model state -------------------------------
    logic [c_dw-1:0] gold [0:c_words-1];
    logic [c_dw-1:0] scan_q[$];
    logic [c_dw-1:0] host_q[$];
    int              m_stalls  = 0;     // consecutive cycles the host has waited
    bit              m_front   = 1'b0;
    bit              m_pending = 1'b0;
    bit              m_done    = 1'b0;  // expected swap_done this cycle
    logic [c_aw:0]   m_last    = '0;
    int              n_pulses  = 0;
    bit              mon_en    = 1'b0;

    function automatic bit scan_bank();
`ifdef FB_DOUBLE_BUFFER_EN
        return m_front;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit host_bank();
`ifdef FB_DOUBLE_BUFFER_EN
        return !m_front;
`else
        return 1'b0;
`endif
    endfunction

    // One clock cycle: drive on the falling edge, check combinational
    // responses shortly after, then advance the model past the next edge.
    task automatic step(input bit rst, input bit fclk, input bit sreq,
                        input logic [c_aw-1:0] saddr, input bit hv, input bit hwe,
                        input logic [c_aw-1:0] haddr, input logic [c_dw-1:0] hwd,
                        input bit swreq);
        bit            e_host, e_scan;
        logic [c_aw:0] e_addr;
        @(negedge clk);
        reset = rst; frame_clk = fclk; scan_req = sreq; scan_addr = saddr;
        host_valid = hv; host_we = hwe; host_addr = haddr; host_wdata = hwd;
        swap_req = swreq;
        #1;
        if (rst) begin
            e_host = 1'b0;
            e_scan = 1'b0;
        end else begin
            e_host = hv && (!sreq || m_stalls >= c_limit);
            e_scan = sreq && !e_host;
        end
        if (e_host)      e_addr = {host_bank(), haddr};
        else if (e_scan) e_addr = {scan_bank(), saddr};
        else             e_addr = m_last;

        chk("host_ready", 64'(host_ready), 64'(e_host));
        chk("scan_gnt",   64'(scan_gnt),   64'(e_scan));
        chk("ram_we",     64'(ram_we),     64'(e_host && hwe));
        chk("swap_done",  64'(swap_done),  64'(m_done));
        if (!rst) chk("ram_addr", 64'(ram_addr), 64'(e_addr));
        if (e_host && hwe) chk("ram_wdata", 64'(ram_wdata), 64'(hwd));
        if (swap_done === 1'b1) n_pulses++;

        if (e_scan)          scan_q.push_back(gold[e_addr]);
        if (e_host && !hwe)  host_q.push_back(gold[e_addr]);
        if (e_host && hwe)   gold[e_addr] = hwd;

        if (rst) begin
            m_stalls = 0; m_front = 1'b0; m_pending = 1'b0; m_done = 1'b0; m_last = '0;
        end else begin
            m_last = e_addr;
            if (e_host)  m_stalls = 0;
            else if (hv) m_stalls = (m_stalls + 1 > c_limit) ? c_limit : m_stalls + 1;
`ifdef FB_DOUBLE_BUFFER_EN
            m_done = m_pending && fclk;
            if (m_pending && fclk) begin
                m_front   = !m_front;
                m_pending = 1'b0;
            end else if (swreq) begin
                m_pending = 1'b1;
            end
`else
            m_done = 1'b0;
`endif
        end
    endtask

    task automatic idle();
        step(0, 0, 0, '0, 0, 0, '0, '0, 0);
    endtask

    // ---------------- monitor: read-return scoreboard ---------------------
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (mon_en) begin
                if (scan_q.size() > 0) begin
                    chk("scan_data_valid", 64'(scan_data_valid), 64'd1);
                    chk("scan_data", 64'(scan_data), 64'(scan_q.pop_front()));
                end else begin
                    chk("scan_data_valid_idle", 64'(scan_data_valid), 64'd0);
                end
                if (host_q.size() > 0) begin
                    chk("host_rdata_valid", 64'(host_rdata_valid), 64'd1);
                    chk("host_rdata", 64'(host_rdata), 64'(host_q.pop_front()));
                end else begin
                    chk("host_rdata_valid_idle", 64'(host_rdata_valid), 64'd0);
                end
            end
        end
    end

    // ---------------- stimulus --------------------------------------------
    initial begin
        int  cyc;
        bit  got;
        int  pulses0;
        bit  exp_db;
        logic [c_aw:0] widx;

`ifdef FB_DOUBLE_BUFFER_EN
        exp_db = 1'b1;
`else
        exp_db = 1'b0;
`endif
        for (int i = 0; i < c_words; i++) gold[i] = init_val(i);

        // Reset with every request asserted
        @(posedge clk);
        mon_en = 1'b1;
        step(1, 1, 1, 9'd3, 1, 1, 9'd4, 24'h123456, 1);
        step(1, 1, 1, 9'd3, 1, 1, 9'd4, 24'h123456, 1);
        idle();

        // Scan-only sweep of one line
        for (int a = 0; a < 64; a++) step(0, 0, 1, 9'(a), 0, 0, '0, '0, 0);
        idle();

        // Starvation: scan held, host write to address 5
        got = 1'b0; cyc = 0;
        for (int k = 1; k <= 20 && !got; k++) begin
            step(0, 0, 1, 9'(k + 100), 1, 1, 9'd5, 24'hABCDEF, 0);
            if (host_ready === 1'b1) begin
                got = 1'b1;
                cyc = k;
            end
        end
        chk("starve_grant_cycle", 64'(cyc), 64'(c_limit + 1));
        widx = {host_bank(), 9'd5};
        idle();
        chk("starve_write_mem", 64'(mem[widx]), 64'h00AB_CDEF);

        // Host read without contention
        step(0, 0, 0, '0, 1, 0, 9'd17, '0, 0);
        idle();
        idle();

        // Swap: request at 10, merged request at 15, frame strobes at 5 and 20
        pulses0 = n_pulses;
        for (int c = 0; c < 26; c++)
            step(0, (c == 5) || (c == 20), 0, '0, 0, 0, '0, '0, (c == 10) || (c == 15));
        chk("swap_pulse_count", 64'(n_pulses - pulses0), 64'(exp_db));
        step(0, 0, 1, 9'd40, 0, 0, '0, '0, 0);
        chk("scan_bank_after_swap", 64'(ram_addr[c_aw]), 64'(exp_db));
        step(0, 0, 0, '0, 1, 1, 9'd41, 24'h00C0DE, 0);
        chk("host_bank_after_swap", 64'(ram_addr[c_aw]), 64'd0);
        step(0, 1, 0, '0, 0, 0, '0, '0, 0);
        idle();

        // Corner: request coinciding with a frame strobe, then reset while pending
        pulses0 = n_pulses;
        step(1, 0, 0, '0, 0, 0, '0, '0, 0);
        step(0, 1, 0, '0, 0, 0, '0, '0, 1);
        idle();
        step(1, 0, 0, '0, 0, 0, '0, '0, 0);
        for (int c = 0; c < 6; c++) step(0, 1, 0, '0, 0, 0, '0, '0, 0);
        chk("corner_no_swap", 64'(n_pulses - pulses0), 64'd0);
        step(0, 0, 1, 9'd7, 0, 0, '0, '0, 0);
        chk("corner_front_bank", 64'(ram_addr[c_aw]), 64'd0);

        // Randomised traffic
        for (int c = 0; c < 800; c++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 3) != 0),
                 9'($urandom),
                 ($urandom_range(0, 2) != 0),
                 $urandom_range(0, 1) == 1,
                 9'($urandom_range(0, 31)),
                 24'($urandom),
                 ($urandom_range(0, 7) == 0));
        end
        idle();
        idle();
        chk("scan_queue_drained", 64'(scan_q.size()), 64'd0);
        chk("host_queue_drained", 64'(host_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
